// File: rtl/ahbl_excl_sram_if.sv
// AHB-Lite bus bundle with exclusive-access sideband (hexcl/hmaster/hexokay).
// The master modport is the requester side; the slave modport is the SRAM side.
interface ahbl_excl_sram_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic              hready;
  logic              hready_resp;
  logic              hresp;
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic [W_DATA-1:0] hwdata;
  logic [W_DATA-1:0] hrdata;
  logic              hexcl;
  logic [7:0]        hmaster;
  logic              hexokay;

  modport master (
    output hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock,
           hwdata, hexcl, hmaster,
    input  hready_resp, hresp, hrdata, hexokay
  );

  modport slave (
    input  hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock,
           hwdata, hexcl, hmaster,
    output hready_resp, hresp, hrdata, hexokay
  );
endinterface

// File: rtl/ahbl_excl_sram.sv
// AHB-Lite SRAM slave with programmable wait states, two-cycle ERROR response
// and a per-master exclusive-access (LR/SC) reservation monitor.
module ahbl_excl_sram #(
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0,
  parameter int N_MASTERS   = 4
) (
  input  logic           clk,
  input  logic           rst,
  ahbl_excl_sram_if.slave ahbls
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int NB = W_DATA / 8;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              hready_resp_q, hready_resp_d;
  logic              hresp_q, hresp_d;
  logic [AW-1:0]     word_q, word_d;
  logic [1:0]        lsb_q, lsb_d;
  logic [1:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              excl_q, excl_d;
  logic [7:0]        master_q, master_d;
  logic [N_MASTERS-1:0] res_vld_q, res_vld_d;
  logic [AW-1:0]     res_word_q [N_MASTERS];
  logic [AW-1:0]     res_word_d [N_MASTERS];
  logic [W_DATA-1:0] mem [DEPTH_WORDS];

  logic          accept, bad, in_range, misaligned;
  logic          data_cyc, master_in, res_hit, excl_ok, wr_en;
  logic [MW-1:0] mid;
  logic [NB-1:0] wr_be;
  logic          unused_ok;

  assign unused_ok = ^{ahbls.hburst, ahbls.hprot, ahbls.hmastlock};

  always_comb begin
    in_range   = (ahbls.haddr >> 2) < W_ADDR'(DEPTH_WORDS);
    misaligned = (ahbls.hsize == 3'd1 && ahbls.haddr[0]) ||
                 (ahbls.hsize == 3'd2 && ahbls.haddr[1:0] != 2'b00);
    bad        = !in_range || (ahbls.hsize > 3'd2) || misaligned;
    // Only cycles that show hready_resp=1 can open a new address phase.
    accept     = hready_resp_q && ahbls.hready && ahbls.htrans[1];

    data_cyc  = (state_q == S_DATA);
    master_in = master_q < 8'(N_MASTERS);
    mid       = master_q[MW-1:0];
    res_hit   = master_in && res_vld_q[mid] && (res_word_q[mid] == word_q);
    excl_ok   = data_cyc && excl_q && master_in && (!write_q || res_hit);
    wr_en     = data_cyc && write_q && (!excl_q || excl_ok) && !rst;

    case (size_q)
      2'd0:    wr_be = NB'(4'b0001 << lsb_q);
      2'd1:    wr_be = lsb_q[1] ? NB'(4'b1100) : NB'(4'b0011);
      default: wr_be = '1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    lsb_d    = lsb_q;
    size_d   = size_q;
    write_d  = write_q;
    excl_d   = excl_q;
    master_d = master_q;

    case (state_q)
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_DATA;
               else cnt_d = cnt_q - 4'd1;
      S_ERR1:  state_d = S_ERR2;
      S_DATA,
      S_ERR2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Accept overrides the fall-back to IDLE so DATA/ERR2 chain with no bubble.
    if (accept) begin
      word_d   = ahbls.haddr[2 +: AW];
      lsb_d    = ahbls.haddr[1:0];
      size_d   = ahbls.hsize[1:0];
      write_d  = ahbls.hwrite;
      excl_d   = ahbls.hexcl;
      master_d = ahbls.hmaster;
      if (bad) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_STATES - 1);
      end else begin
        state_d = S_DATA;
      end
    end

    hready_resp_d = !(state_d == S_WAIT || state_d == S_ERR1);
    hresp_d       = (state_d == S_ERR1 || state_d == S_ERR2);
  end

  always_comb begin
    res_vld_d  = res_vld_q;
    res_word_d = res_word_q;
    if (data_cyc) begin
      if (!write_q) begin
        if (excl_q && master_in) begin
          res_vld_d[mid]  = 1'b1;
          res_word_d[mid] = word_q;
        end
      end else if (excl_q && !excl_ok) begin
        if (master_in) res_vld_d[mid] = 1'b0;
      end else begin
        // Any store that lands kills every reservation on that word.
        for (int i = 0; i < N_MASTERS; i++) begin
          if (res_word_q[i] == word_q) res_vld_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      hready_resp_q <= 1'b1;
      hresp_q       <= 1'b0;
      res_vld_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hready_resp_q <= hready_resp_d;
      hresp_q       <= hresp_d;
      res_vld_q     <= res_vld_d;
    end
    word_q     <= word_d;
    lsb_q      <= lsb_d;
    size_q     <= size_d;
    write_q    <= write_d;
    excl_q     <= excl_d;
    master_q   <= master_d;
    res_word_q <= res_word_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[word_q][8*b +: 8] <= ahbls.hwdata[8*b +: 8];
      end
    end
  end

  assign ahbls.hready_resp = hready_resp_q;
  assign ahbls.hresp       = hresp_q;
  assign ahbls.hexokay     = excl_ok;
  assign ahbls.hrdata      = (data_cyc && !write_q) ? mem[word_q] : '0;
endmodule

// File: tb/tb_ahbl_excl_sram.sv
// Bench for ahbl_excl_sram: directed scenarios plus random traffic, checked every
// cycle against a transaction-level memory/reservation model.
module tb_ahbl_excl_sram;
  localparam int WS    = 2;
  localparam int DEPTH = 64;
  localparam int NM    = 4;

  typedef struct packed {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic        excl;
    logic [7:0]  mst;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahbl_excl_sram_if #(.W_ADDR(32), .W_DATA(32)) bus ();
  assign bus.hready = bus.hready_resp;

  ahbl_excl_sram #(
    .W_ADDR(32), .W_DATA(32), .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS), .N_MASTERS(NM)
  ) dut (
    .clk(clk), .rst(rst), .ahbls(bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state
  logic [31:0] mmem   [DEPTH];
  logic [3:0]  mknown [DEPTH];
  bit          rv [NM];
  int          rw [NM];
  bit          p_vld, p_err, p_wr, p_ex;
  logic [31:0] p_addr;
  logic [2:0]  p_size;
  int          p_mst, p_word, p_k;
  logic [31:0] last_rdata;
  logic        last_exok, last_resp;
  int          last_k;

  txn_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b1;
    if ((a % (32'd1 << s)) != 0) return 1'b1;
    return (a / 4) >= DEPTH;
  endfunction

  function automatic bit model_exok();
    if (!p_ex || p_mst >= NM) return 1'b0;
    if (!p_wr) return 1'b1;
    return rv[p_mst] && (rw[p_mst] == p_word);
  endfunction

  task automatic complete_txn();
    bit ok;
    int lane;
    last_rdata = bus.hrdata;
    last_exok  = bus.hexokay;
    last_resp  = bus.hresp;
    last_k     = p_k;
    if (p_err) return;
    if (p_wr) begin
      ok = !p_ex || model_exok();
      if (ok) begin
        for (int i = 0; i < (1 << p_size); i++) begin
          lane = int'(p_addr % 4) + i;
          mmem[p_word][8*lane +: 8] = bus.hwdata[8*lane +: 8];
          mknown[p_word][lane] = 1'b1;
        end
        for (int i = 0; i < NM; i++) if (rw[i] == p_word) rv[i] = 1'b0;
      end else if (p_mst < NM) begin
        rv[p_mst] = 1'b0;
      end
    end else if (p_ex && p_mst < NM) begin
      rv[p_mst] = 1'b1;
      rw[p_mst] = p_word;
    end
  endtask

  task automatic compare_cycle();
    logic        e_rdy, e_resp, e_ex;
    logic [31:0] e_rd, kmask;
    e_rdy = 1'b1; e_resp = 1'b0; e_ex = 1'b0; e_rd = 32'h0; kmask = 32'hFFFF_FFFF;
    if (p_vld) begin
      if (p_err) begin
        e_rdy  = (p_k >= 1);
        e_resp = 1'b1;
      end else begin
        e_rdy = (p_k >= WS);
        e_ex  = e_rdy && model_exok();
        if (e_rdy && p_wr) kmask = 32'h0;
        if (e_rdy && !p_wr) begin
          e_rd = mmem[p_word];
          for (int b = 0; b < 4; b++) kmask[8*b +: 8] = mknown[p_word][b] ? 8'hFF : 8'h00;
        end
      end
    end
    chk("ctl_rdy_resp_exok", {29'b0, bus.hready_resp, bus.hresp, bus.hexokay},
        {29'b0, e_rdy, e_resp, e_ex});
    chk("hrdata", bus.hrdata & kmask, e_rd & kmask);

    // advance the model to what the coming clock edge does
    if (rst) begin
      p_vld = 1'b0;
      for (int i = 0; i < NM; i++) rv[i] = 1'b0;
    end else if (bus.hready_resp) begin
      if (p_vld) complete_txn();
      p_vld = bus.htrans[1];
      if (p_vld) begin
        p_addr = bus.haddr;
        p_size = bus.hsize;
        p_wr   = bus.hwrite;
        p_ex   = bus.hexcl;
        p_mst  = int'(bus.hmaster);
        p_err  = is_err(bus.haddr, bus.hsize);
        p_word = int'(bus.haddr / 4);
        p_k    = 0;
      end
    end else if (p_vld) begin
      p_k++;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mknown[i] = 4'h0;
    for (int i = 0; i < NM; i++) begin rv[i] = 1'b0; rw[i] = 0; end
    p_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) compare_cycle();
    end
  end

  task automatic drive(input bit v, input txn_t t);
    if (v) begin
      bus.htrans  = t.trans;
      bus.haddr   = t.addr;
      bus.hwrite  = t.wr;
      bus.hsize   = t.size;
      bus.hexcl   = t.excl;
      bus.hmaster = t.mst;
    end else begin
      bus.htrans  = 2'b00;
      bus.haddr   = $urandom;
      bus.hwrite  = 1'($urandom);
      bus.hsize   = 3'd2;
      bus.hexcl   = 1'b0;
      bus.hmaster = 8'd0;
    end
    bus.hburst    = 3'd0;
    bus.hprot     = 4'h3;
    bus.hmastlock = 1'b0;
  endtask

  // Pipelined AHB master: address of the next item overlaps the data phase of the last.
  task automatic run_queue(input int bound);
    txn_t        cur;
    bit          cur_v, dp_v, r;
    logic [31:0] dp_wd;
    int          n;
    n = 0; dp_v = 1'b0; dp_wd = 32'h0; cur = '0;
    cur_v = (q.size() > 0);
    if (cur_v) cur = q.pop_front();
    while ((cur_v || dp_v) && n < bound) begin
      drive(cur_v, cur);
      bus.hwdata = dp_wd;
      @(negedge clk);
      r = bus.hready_resp;
      @(posedge clk);
      #1;
      n++;
      if (r) begin
        dp_v  = cur_v && cur.trans[1];
        dp_wd = cur.wdata;
        cur_v = (q.size() > 0);
        if (cur_v) cur = q.pop_front();
      end
    end
    drive(1'b0, cur);
    chk("bus_progress_within_bound", 32'(n < bound), 32'd1);
  endtask

  function automatic txn_t mk(input logic [31:0] a, input bit wr, input logic [2:0] s,
                              input bit ex, input logic [7:0] m, input logic [31:0] wd);
    txn_t t;
    t.trans = 2'b10; t.addr = a; t.wr = wr; t.size = s; t.excl = ex; t.mst = m; t.wdata = wd;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   r, off;
    r = int'($urandom_range(0, 15));
    t.trans = (r < 2) ? 2'b00 : (r < 3) ? 2'b01 : (r < 10) ? 2'b10 : 2'b11;
    t.size  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    off = int'($urandom_range(0, 3));
    if ($urandom_range(0, 7) != 0 && t.size <= 3'd2) off = off & ~((1 << t.size) - 1);
    t.addr  = ($urandom_range(0, 15) == 0) ? 32'(DEPTH * 4 + int'($urandom_range(0, 31)))
                                           : 32'(int'($urandom_range(0, 7)) * 4 + off);
    t.wr    = 1'($urandom_range(0, 1));
    t.excl  = 1'($urandom_range(0, 1));
    t.mst   = 8'($urandom_range(0, 5));
    t.wdata = $urandom;
    return t;
  endfunction

  initial begin
    txn_t t0;
    t0 = '0;
    drive(1'b0, t0);
    bus.hwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_hready_resp", 32'(bus.hready_resp), 32'd1);
    chk("reset_hresp", 32'(bus.hresp), 32'd0);
    chk("reset_hexokay", 32'(bus.hexokay), 32'd0);
    chk("reset_hrdata", bus.hrdata, 32'h0);
    @(posedge clk); #1;

    // word write then read, with wait states
    q.push_back(mk(32'h10, 1, 3'd2, 0, 8'd0, 32'hDEAD_BEEF));
    q.push_back(mk(32'h10, 0, 3'd2, 0, 8'd0, 32'h0));
    run_queue(100);
    chk("ws_read_data", last_rdata, 32'hDEAD_BEEF);
    chk("ws_wait_cycles", 32'(last_k), 32'(WS));
    chk("model_word4", mmem[4], 32'hDEAD_BEEF);

    // byte write then back-to-back word read of the merged word
    q.push_back(mk(32'h13, 1, 3'd0, 0, 8'd0, 32'hAA00_0000));
    q.push_back(mk(32'h10, 0, 3'd2, 0, 8'd0, 32'h0));
    run_queue(100);
    chk("byte_merge_read", last_rdata, 32'hAAAD_BEEF);

    // exclusive pair by m0 succeeds once, the retry fails
    q.push_back(mk(32'h20, 1, 3'd2, 0, 8'd0, 32'h1111_1111));
    q.push_back(mk(32'h20, 0, 3'd2, 1, 8'd0, 32'h0));
    run_queue(100);
    chk("excl_read_m0_okay", 32'(last_exok), 32'd1);
    q.push_back(mk(32'h20, 1, 3'd2, 1, 8'd0, 32'h1234_5678));
    run_queue(100);
    chk("excl_write_m0_okay", 32'(last_exok), 32'd1);
    q.push_back(mk(32'h20, 0, 3'd2, 0, 8'd0, 32'h0));
    run_queue(100);
    chk("excl_write_data", last_rdata, 32'h1234_5678);
    q.push_back(mk(32'h20, 1, 3'd2, 1, 8'd0, 32'h9999_9999));
    run_queue(100);
    chk("excl_retry_fails", 32'(last_exok), 32'd0);
    q.push_back(mk(32'h20, 0, 3'd2, 0, 8'd0, 32'h0));
    run_queue(100);
    chk("excl_retry_no_write", last_rdata, 32'h1234_5678);

    // plain write by m2 breaks m1's reservation
    q.push_back(mk(32'h20, 0, 3'd2, 1, 8'd0, 32'h0));
    q.push_back(mk(32'h20, 0, 3'd2, 1, 8'd1, 32'h0));
    q.push_back(mk(32'h20, 1, 3'd2, 0, 8'd2, 32'h5555_5555));
    q.push_back(mk(32'h20, 1, 3'd2, 1, 8'd1, 32'h6666_6666));
    run_queue(100);
    chk("excl_after_plain_fails", 32'(last_exok), 32'd0);
    q.push_back(mk(32'h20, 0, 3'd2, 0, 8'd1, 32'h0));
    run_queue(100);
    chk("excl_after_plain_data", last_rdata, 32'h5555_5555);

    // error responses leave memory alone
    q.push_back(mk(32'h0, 1, 3'd2, 0, 8'd0, 32'h0BAD_F00D));
    q.push_back(mk(32'(DEPTH * 4), 0, 3'd2, 0, 8'd0, 32'h0));
    run_queue(100);
    chk("oob_hresp", 32'(last_resp), 32'd1);
    chk("oob_err1_cycles", 32'(last_k), 32'd1);
    q.push_back(mk(32'h2, 1, 3'd2, 0, 8'd0, 32'hFFFF_FFFF));
    run_queue(100);
    chk("unaligned_hresp", 32'(last_resp), 32'd1);
    q.push_back(mk(32'h0, 0, 3'd2, 0, 8'd0, 32'h0));
    run_queue(100);
    chk("after_err_data", last_rdata, 32'h0BAD_F00D);
    chk("after_err_okay", 32'(last_resp), 32'd0);

    // reset in the middle of a write's wait states
    q.push_back(mk(32'h30, 1, 3'd2, 0, 8'd0, 32'hCAFE_0001));
    run_queue(100);
    drive(1'b1, mk(32'h30, 1, 3'd2, 0, 8'd0, 32'h0));
    @(negedge clk);
    @(posedge clk); #1;
    drive(1'b0, t0);
    bus.hwdata = 32'h7777_7777;
    @(negedge clk);
    chk("rst_test_in_wait", 32'(bus.hready_resp), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_abort_hready_resp", 32'(bus.hready_resp), 32'd1);
    chk("rst_abort_hexokay", 32'(bus.hexokay), 32'd0);
    @(posedge clk); #1;
    q.push_back(mk(32'h30, 0, 3'd2, 0, 8'd0, 32'h0));
    run_queue(100);
    chk("rst_abort_no_write", last_rdata, 32'hCAFE_0001);

    // random traffic
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 20; i++) q.push_back(rand_txn());
      run_queue(400);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
